// File: rtl/add_stream_if.sv
// -----------------------------------------------------------------------------
// add_stream_if
//
// Purpose: bundles the input and output valid/ready streams of add_stream.
//
// Parameters:
//   WIDTH  data width of s_data, s_addend and m_data
//
// Signals:
//   s_valid, s_ready, s_data, s_addend, s_use_addend   input stream (A, B select)
//   m_valid, m_ready, m_data, m_carry                  output stream (sum, carry)
//
// Modports:
//   slave   the add_stream block (consumes s_*, produces m_*)
//   master  the surrounding environment (produces s_*, consumes m_*)
// -----------------------------------------------------------------------------
interface add_stream_if #(
  parameter int WIDTH = 8
);
  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] s_data;
  logic [WIDTH-1:0] s_addend;
  logic             s_use_addend;

  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;
  logic             m_carry;

  modport slave (
    input  s_valid, s_data, s_addend, s_use_addend, m_ready,
    output s_ready, m_valid, m_data, m_carry
  );

  modport master (
    output s_valid, s_data, s_addend, s_use_addend, m_ready,
    input  s_ready, m_valid, m_data, m_carry
  );
endinterface

// File: rtl/add_stream.sv
// -----------------------------------------------------------------------------
// add_stream
//
// Purpose: streaming adder. Every accepted input word A is added to either a
// constant STEP or a per-beat addend B at WIDTH+1 bits; the WIDTH-bit result
// and the carry-out are stored in a 2-entry FIFO that feeds the output stream.
// Sustains one word per clock with a registered s_ready. Also counts completed
// output transfers for debug.
//
// Parameters:
//   WIDTH  data width (1..32)
//   STEP   constant addend used when s_use_addend=0, truncated to WIDTH bits
//   CNT_W  width of xfer_count
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous, active-high reset
//   bus         add_stream_if.slave: s_valid/s_ready/s_data/s_addend/
//               s_use_addend in, m_valid/m_ready/m_data/m_carry out
//   xfer_count  number of output handshakes since reset (wraps)
//
// Build option:
//   ADD_STREAM_SAT_EN  when defined, a sum that overflows is clamped to all
//                      ones and m_carry flags that the clamp happened.
//                      Otherwise m_data wraps and m_carry is the raw carry.
// -----------------------------------------------------------------------------
module add_stream #(
  parameter int          WIDTH = 8,
  parameter int unsigned STEP  = 1,
  parameter int          CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  add_stream_if.slave      bus,
  output logic [CNT_W-1:0] xfer_count
);

  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

  // FIFO storage and bookkeeping
  logic [WIDTH-1:0] data_reg [2];
  logic             carry_reg [2];
  logic             head_reg;
  logic             tail_reg;
  logic [1:0]       count_reg;
  logic [1:0]       count_next;
  logic             s_ready_reg;
  logic             s_ready_next;
  logic [CNT_W-1:0] xfer_count_reg;

  logic             push;
  logic             pop;
  logic             m_valid_int;

  // Arithmetic for the word being accepted this cycle
  logic [WIDTH-1:0] operand_b;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] wr_data;
  logic             wr_carry;

  assign m_valid_int = (count_reg != 2'd0);
  assign push        = bus.s_valid && s_ready_reg;
  assign pop         = m_valid_int && bus.m_ready;

  assign operand_b = bus.s_use_addend ? bus.s_addend : STEP_W;
  assign sum       = {1'b0, bus.s_data} + {1'b0, operand_b};

`ifdef ADD_STREAM_SAT_EN
  // Clamp on overflow; the carry bit doubles as the "clamped" flag.
  assign wr_data  = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
  assign wr_carry = sum[WIDTH];
`else
  assign wr_data  = sum[WIDTH-1:0];
  assign wr_carry = sum[WIDTH];
`endif

  // Occupancy after this edge; s_ready is registered from it so that a pop
  // at full occupancy only reopens the input one cycle later.
  always_comb begin
    count_next   = count_reg;
    s_ready_next = 1'b0;
    case ({push, pop})
      2'b10:   count_next = count_reg + 2'd1;
      2'b01:   count_next = count_reg - 2'd1;
      default: count_next = count_reg;
    endcase
    s_ready_next = (count_next < 2'd2);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        data_reg[i]  <= '0;
        carry_reg[i] <= 1'b0;
      end
      head_reg       <= 1'b0;
      tail_reg       <= 1'b0;
      count_reg      <= 2'd0;
      s_ready_reg    <= 1'b0;
      xfer_count_reg <= '0;
    end else begin
      if (push) begin
        data_reg[tail_reg]  <= wr_data;
        carry_reg[tail_reg] <= wr_carry;
        tail_reg            <= ~tail_reg;
      end
      if (pop) begin
        head_reg       <= ~head_reg;
        xfer_count_reg <= xfer_count_reg + CNT_W'(1);
      end
      count_reg   <= count_next;
      s_ready_reg <= s_ready_next;
    end
  end

  assign bus.s_ready = s_ready_reg;
  assign bus.m_valid = m_valid_int;
  assign bus.m_data  = data_reg[head_reg];
  assign bus.m_carry = carry_reg[head_reg];
  assign xfer_count  = xfer_count_reg;

endmodule

// File: tb/tb_add_stream.sv
// -----------------------------------------------------------------------------
// tb_add_stream
//
// Self-checking bench for add_stream. A queue-based reference model tracks
// the words held in the output buffer, the expected s_ready and the transfer
// count; words leaving the DUT are compared in order against the model.
// Honors ADD_STREAM_SAT_EN for the expected arithmetic.
// -----------------------------------------------------------------------------
module tb_add_stream;

  localparam int          WIDTH = 8;
  localparam int unsigned STEP  = 1;
  localparam int          CNT_W = 5;

  typedef logic [WIDTH:0] word_t;  // {carry, data}

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [CNT_W-1:0] xfer_count;

  add_stream_if #(.WIDTH(WIDTH)) bus ();

  add_stream #(
    .WIDTH (WIDTH),
    .STEP  (STEP),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .xfer_count (xfer_count)
  );

  always #5 clk = ~clk;

  // Reference model state
  word_t       exp_fifo[$];
  bit          exp_ready = 1'b0;
  int unsigned exp_cnt   = 0;
  word_t       pop_exp_q[$];
  word_t       pop_obs_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  function automatic word_t ref_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    int unsigned s;
    int unsigned lim;
    s   = 32'(a) + 32'(b);
    lim = 32'd1 << WIDTH;
    if (s >= lim) begin
`ifdef ADD_STREAM_SAT_EN
      return {1'b1, WIDTH'(lim - 1)};
`else
      return {1'b1, WIDTH'(s - lim)};
`endif
    end
    return {1'b0, WIDTH'(s)};
  endfunction

  // Advance one clock, updating the model from the handshakes at this edge.
  task automatic tick(output bit pushed);
    bit    mpush;
    bit    mpop;
    word_t obs;
    word_t nw;
    mpush = bus.s_valid && exp_ready;
    mpop  = (exp_fifo.size() != 0) && bus.m_ready;
    obs   = {bus.m_carry, bus.m_data};
    nw    = ref_add(bus.s_data, bus.s_use_addend ? bus.s_addend : WIDTH'(STEP));
    @(posedge clk);
    #1;
    pushed = 1'b0;
    if (rst) begin
      exp_fifo.delete();
      exp_ready = 1'b0;
      exp_cnt   = 0;
    end else begin
      if (mpop) begin
        pop_exp_q.push_back(exp_fifo.pop_front());
        pop_obs_q.push_back(obs);
        exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
      end
      if (mpush) begin
        exp_fifo.push_back(nw);
        pushed = 1'b1;
      end
      exp_ready = (exp_fifo.size() < 2);
    end
  endtask

  task automatic test_reset();
    bit p;
    rst = 1'b1;
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b0;
    bus.s_data = '0;
    bus.s_addend = '0;
    bus.s_use_addend = 1'b0;
    tick(p);
    tick(p);
    n_checks += 5;
    if (bus.s_ready !== 1'b0) begin n_fail++; $display("FAIL reset_s_ready: got %b want 0", bus.s_ready); end
    if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid: got %b want 0", bus.m_valid); end
    if (bus.m_data !== 8'h00) begin n_fail++; $display("FAIL reset_m_data: got %h want 00", bus.m_data); end
    if (bus.m_carry !== 1'b0) begin n_fail++; $display("FAIL reset_m_carry: got %b want 0", bus.m_carry); end
    if (xfer_count !== '0) begin n_fail++; $display("FAIL reset_xfer_count: got %0d want 0", xfer_count); end
    rst = 1'b0;
    tick(p);
    n_checks++;
    if (bus.s_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_s_ready: got %b want 1", bus.s_ready); end
    $display("test_reset done");
  endtask

  task automatic test_single();
    bit p;
    word_t o;
    word_t e;
    bus.s_data = 8'h05;
    bus.s_use_addend = 1'b0;
    bus.s_valid = 1'b1;
    tick(p);
    bus.s_valid = 1'b0;
    n_checks += 3;
    if (bus.m_valid !== 1'b1) begin n_fail++; $display("FAIL single_m_valid: got %b want 1", bus.m_valid); end
    if (bus.m_data !== 8'h06) begin n_fail++; $display("FAIL single_m_data: got %h want 06", bus.m_data); end
    if (bus.m_carry !== 1'b0) begin n_fail++; $display("FAIL single_m_carry: got %b want 0", bus.m_carry); end
    bus.m_ready = 1'b1;
    tick(p);
    bus.m_ready = 1'b0;
    n_checks += 2;
    if (xfer_count !== CNT_W'(1)) begin n_fail++; $display("FAIL single_xfer_count: got %0d want 1", xfer_count); end
    if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL single_empty: got %b want 0", bus.m_valid); end
    while (pop_obs_q.size() != 0) begin
      o = pop_obs_q.pop_front();
      e = pop_exp_q.pop_front();
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL single_pop: got %h want %h", o, e); end
    end
    $display("test_single: pushed 05 -> 06, xfer_count=%0d", xfer_count);
  endtask

  task automatic test_wrap();
    bit p;
    logic [WIDTH-1:0] a_tab[3];
    logic [WIDTH-1:0] b_tab[3];
    logic             u_tab[3];
    logic [WIDTH-1:0] d_tab[3];
    logic             c_tab[3];
    a_tab = '{8'hFF, 8'hF0, 8'h10};
    b_tab = '{8'h00, 8'h20, 8'h20};
    u_tab = '{1'b0, 1'b1, 1'b1};
`ifdef ADD_STREAM_SAT_EN
    d_tab = '{8'hFF, 8'hFF, 8'h30};
`else
    d_tab = '{8'h00, 8'h10, 8'h30};
`endif
    c_tab = '{1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      bus.s_data = a_tab[i];
      bus.s_addend = b_tab[i];
      bus.s_use_addend = u_tab[i];
      bus.s_valid = 1'b1;
      tick(p);
      bus.s_valid = 1'b0;
      n_checks += 2;
      if (bus.m_data !== d_tab[i]) begin n_fail++; $display("FAIL wrap_data[%0d]: got %h want %h", i, bus.m_data, d_tab[i]); end
      if (bus.m_carry !== c_tab[i]) begin n_fail++; $display("FAIL wrap_carry[%0d]: got %b want %b", i, bus.m_carry, c_tab[i]); end
      $display("test_wrap: %h + %h -> data=%h carry=%b", a_tab[i], u_tab[i] ? b_tab[i] : WIDTH'(STEP), bus.m_data, bus.m_carry);
      bus.m_ready = 1'b1;
      tick(p);
      bus.m_ready = 1'b0;
    end
    pop_obs_q.delete();
    pop_exp_q.delete();
  endtask

  task automatic test_backpressure();
    bit p;
    logic [WIDTH-1:0] want_tab[3];
    word_t o;
    word_t e;
    want_tab = '{8'h04, 8'h08, 8'h0A};
    bus.m_ready = 1'b0;
    bus.s_use_addend = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_data = 8'h03;
    tick(p);
    bus.s_data = 8'h07;
    tick(p);
    n_checks++;
    if (bus.s_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_s_ready: got %b want 0", bus.s_ready); end
    bus.s_data = 8'h09;
    for (int i = 0; i < 3; i++) begin
      tick(p);
      n_checks += 3;
      if (bus.s_ready !== 1'b0) begin n_fail++; $display("FAIL bp_hold_s_ready: got %b want 0", bus.s_ready); end
      if (bus.m_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_m_valid: got %b want 1", bus.m_valid); end
      if (bus.m_data !== 8'h04) begin n_fail++; $display("FAIL bp_hold_m_data: got %h want 04", bus.m_data); end
    end
    bus.m_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick(p);
      if (p) bus.s_valid = 1'b0;
      if (i == 0) begin
        n_checks++;
        if (bus.s_ready !== 1'b1) begin n_fail++; $display("FAIL bp_reopen_s_ready: got %b want 1", bus.s_ready); end
      end
    end
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b0;
    n_checks++;
    if (pop_obs_q.size() != 3) begin n_fail++; $display("FAIL bp_pop_count: got %0d want 3", pop_obs_q.size()); end
    for (int i = 0; i < 3 && pop_obs_q.size() != 0; i++) begin
      o = pop_obs_q.pop_front();
      e = pop_exp_q.pop_front();
      n_checks += 2;
      if (o !== e) begin n_fail++; $display("FAIL bp_pop_model[%0d]: got %h want %h", i, o, e); end
      if (o[WIDTH-1:0] !== want_tab[i]) begin n_fail++; $display("FAIL bp_pop_order[%0d]: got %h want %h", i, o[WIDTH-1:0], want_tab[i]); end
      $display("test_backpressure: pop %0d data=%h", i, o[WIDTH-1:0]);
    end
    pop_obs_q.delete();
    pop_exp_q.delete();
  endtask

  task automatic test_throughput();
    bit p;
    word_t o;
    word_t e;
    bus.m_ready = 1'b1;
    bus.s_use_addend = 1'b0;
    bus.s_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.s_data = WIDTH'(i);
      n_checks++;
      if (bus.s_ready !== 1'b1) begin n_fail++; $display("FAIL tp_s_ready[%0d]: got %b want 1", i, bus.s_ready); end
      tick(p);
      n_checks++;
      if (bus.m_valid !== 1'b1) begin n_fail++; $display("FAIL tp_m_valid[%0d]: got %b want 1", i, bus.m_valid); end
    end
    bus.s_valid = 1'b0;
    tick(p);
    bus.m_ready = 1'b0;
    n_checks += 2;
    if (pop_obs_q.size() != 20) begin n_fail++; $display("FAIL tp_pop_count: got %0d want 20", pop_obs_q.size()); end
    if (xfer_count !== CNT_W'(exp_cnt)) begin n_fail++; $display("FAIL tp_xfer_count: got %0d want %0d", xfer_count, exp_cnt); end
    for (int i = 0; i < 20 && pop_obs_q.size() != 0; i++) begin
      o = pop_obs_q.pop_front();
      e = pop_exp_q.pop_front();
      n_checks += 2;
      if (o !== e) begin n_fail++; $display("FAIL tp_pop_model[%0d]: got %h want %h", i, o, e); end
      if (o[WIDTH-1:0] !== WIDTH'(i + 1)) begin n_fail++; $display("FAIL tp_pop_value[%0d]: got %h want %h", i, o[WIDTH-1:0], WIDTH'(i + 1)); end
    end
    $display("test_throughput: 20 words streamed, xfer_count=%0d", xfer_count);
    pop_obs_q.delete();
    pop_exp_q.delete();
  endtask

  task automatic test_random();
    bit p;
    word_t o;
    word_t e;
    int n_push = 0;
    int n_pop  = 0;
    bus.s_valid = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      // Only re-draw the input beat once the previous one was taken.
      if (!(bus.s_valid && !exp_ready)) begin
        bus.s_valid = ($urandom_range(0, 3) != 0);
        bus.s_data = WIDTH'($urandom);
        bus.s_addend = WIDTH'($urandom);
        bus.s_use_addend = $urandom_range(0, 1) != 0;
      end
      bus.m_ready = ($urandom_range(0, 3) != 0);
      n_checks += 3;
      if (bus.s_ready !== exp_ready) begin n_fail++; $display("FAIL rnd_s_ready[%0d]: got %b want %b", cyc, bus.s_ready, exp_ready); end
      if (bus.m_valid !== (exp_fifo.size() != 0)) begin n_fail++; $display("FAIL rnd_m_valid[%0d]: got %b want %b", cyc, bus.m_valid, exp_fifo.size() != 0); end
      if (xfer_count !== CNT_W'(exp_cnt)) begin n_fail++; $display("FAIL rnd_xfer_count[%0d]: got %0d want %0d", cyc, xfer_count, exp_cnt); end
      if (exp_fifo.size() != 0) begin
        n_checks++;
        if ({bus.m_carry, bus.m_data} !== exp_fifo[0]) begin n_fail++; $display("FAIL rnd_head[%0d]: got %h want %h", cyc, {bus.m_carry, bus.m_data}, exp_fifo[0]); end
      end
      tick(p);
      if (p) n_push++;
    end
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick(p);
    bus.m_ready = 1'b0;
    while (pop_obs_q.size() != 0) begin
      o = pop_obs_q.pop_front();
      e = pop_exp_q.pop_front();
      n_pop++;
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL rnd_pop[%0d]: got %h want %h", n_pop, o, e); end
    end
    n_checks++;
    if (n_pop != n_push) begin n_fail++; $display("FAIL rnd_pop_count: got %0d want %0d", n_pop, n_push); end
    $display("test_random: %0d pushes, %0d pops, xfer_count=%0d", n_push, n_pop, xfer_count);
  endtask

  task automatic test_reset_mid();
    bit p;
    word_t o;
    word_t e;
    bus.m_ready = 1'b0;
    bus.s_use_addend = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_data = 8'h40;
    tick(p);
    bus.s_data = 8'h41;
    tick(p);
    bus.s_valid = 1'b0;
    n_checks += 3;
    if (bus.m_valid !== 1'b1) begin n_fail++; $display("FAIL rm_pre_m_valid: got %b want 1", bus.m_valid); end
    if (bus.s_ready !== 1'b0) begin n_fail++; $display("FAIL rm_pre_s_ready: got %b want 0", bus.s_ready); end
    if (xfer_count === '0) begin n_fail++; $display("FAIL rm_pre_xfer_count: got 0 want nonzero"); end
    // Reset must win over a pop attempted in the same cycle.
    rst = 1'b1;
    bus.m_ready = 1'b1;
    tick(p);
    n_checks += 4;
    if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL rm_m_valid: got %b want 0", bus.m_valid); end
    if (xfer_count !== '0) begin n_fail++; $display("FAIL rm_xfer_count: got %0d want 0", xfer_count); end
    if (bus.s_ready !== 1'b0) begin n_fail++; $display("FAIL rm_s_ready: got %b want 0", bus.s_ready); end
    if (bus.m_data !== 8'h00) begin n_fail++; $display("FAIL rm_m_data: got %h want 00", bus.m_data); end
    pop_obs_q.delete();
    pop_exp_q.delete();
    rst = 1'b0;
    bus.m_ready = 1'b0;
    tick(p);
    n_checks += 2;
    if (bus.s_ready !== 1'b1) begin n_fail++; $display("FAIL rm_release_s_ready: got %b want 1", bus.s_ready); end
    if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL rm_no_stale: got %b want 0", bus.m_valid); end
    bus.s_valid = 1'b1;
    bus.s_data = 8'h22;
    tick(p);
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick(p);
    bus.m_ready = 1'b0;
    n_checks += 2;
    if (pop_obs_q.size() != 1) begin n_fail++; $display("FAIL rm_pop_count: got %0d want 1", pop_obs_q.size()); end
    if (xfer_count !== CNT_W'(1)) begin n_fail++; $display("FAIL rm_post_xfer_count: got %0d want 1", xfer_count); end
    while (pop_obs_q.size() != 0) begin
      o = pop_obs_q.pop_front();
      e = pop_exp_q.pop_front();
      n_checks += 2;
      if (o !== e) begin n_fail++; $display("FAIL rm_pop_model: got %h want %h", o, e); end
      if (o[WIDTH-1:0] !== 8'h23) begin n_fail++; $display("FAIL rm_pop_value: got %h want 23", o[WIDTH-1:0]); end
    end
    $display("test_reset_mid: reset flushed buffer, next word ok");
  endtask

  initial begin
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b0;
    bus.s_data = '0;
    bus.s_addend = '0;
    bus.s_use_addend = 1'b0;
    test_reset();
    test_single();
    test_wrap();
    test_backpressure();
    test_throughput();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
